// File: rtl/uart_tx_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between NUM_REQ byte streams.
//                Round-robin selection with frame locking (a requester keeps
//                the UART until it sends a byte marked last, or goes quiet
//                for LOCK_TIMEOUT idle cycles). One byte in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,     // 2..4 requesters
    parameter int LOCK_TIMEOUT = 1024,  // idle cycles before a frame lock drops
    parameter int BUSY_WAIT    = 4      // >= 2; cycles allowed for tx_busy to rise
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 locked
);

    localparam int c_ptr_w  = $clog2(NUM_REQ);
    localparam int c_idle_w = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_wait_w = $clog2(BUSY_WAIT + 1);

    localparam logic [c_ptr_w-1:0]  c_last_ptr = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_ptr_w:0]    c_num_req  = (c_ptr_w + 1)'(NUM_REQ);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(LOCK_TIMEOUT - 1);
    // The wait window counts the tx_start cycle itself, so the timeout path
    // returns to IDLE BUSY_WAIT+1 cycles after ISSUE.
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_tx_data;
    logic [NUM_REQ-1:0]    r_grant;
    logic [c_ptr_w-1:0]    r_rr_ptr;     // last winner; also the lock owner
    logic                  r_locked;
    logic [c_idle_w-1:0]   r_idle_cnt;
    logic [c_wait_w-1:0]   r_wait_cnt;

    logic                  w_sel_found;
    logic [c_ptr_w-1:0]    w_sel_idx;
    logic [c_ptr_w:0]      w_cand;
    logic [NUM_REQ-1:0]    w_sel_onehot;
    logic                  w_accept;
    logic                  w_owner_idle;

    // Pick a winner: only the owner while locked, else round-robin after rr_ptr.
    // The loop runs from lowest to highest priority so the last hit wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = r_rr_ptr;
        w_cand      = '0;
        if (r_locked) begin
            w_sel_found = req_valid[r_rr_ptr];
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                w_cand = {1'b0, r_rr_ptr} + (c_ptr_w + 1)'(k);
                if (w_cand >= c_num_req) begin
                    w_cand = w_cand - c_num_req;
                end
                if (req_valid[w_cand[c_ptr_w-1:0]]) begin
                    w_sel_found = 1'b1;
                    w_sel_idx   = w_cand[c_ptr_w-1:0];
                end
            end
        end
    end

    // One-hot form of the selected requester.
    always_comb begin
        w_sel_onehot            = '0;
        w_sel_onehot[w_sel_idx] = 1'b1;
    end

    assign w_accept     = (r_state == ST_IDLE) && !tx_busy && !rst && w_sel_found;
    assign w_owner_idle = (r_state == ST_IDLE) && r_locked && !req_valid[r_rr_ptr];

    assign req_ready = w_accept ? w_sel_onehot : '0;
    assign tx_start  = (r_state == ST_ISSUE);
    assign tx_data   = r_tx_data;
    assign grant     = r_grant;
    assign locked    = r_locked;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept -> pulse start -> wait for busy -> wait for done.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy || (r_wait_cnt >= c_wait_max)) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Byte capture, ownership, frame lock, lock timeout and busy-wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data  <= 8'h00;
            r_grant    <= '0;
            r_rr_ptr   <= c_last_ptr;
            r_locked   <= 1'b0;
            r_idle_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_tx_data  <= req_data[{w_sel_idx, 3'b000} +: 8];
                r_grant    <= w_sel_onehot;
                r_rr_ptr   <= w_sel_idx;
                r_locked   <= !req_last[w_sel_idx];
                r_idle_cnt <= '0;
                r_wait_cnt <= '0;
            end else if (w_owner_idle) begin
                // Owner has gone quiet mid-frame; release after the timeout,
                // leaving rr_ptr on the old owner.
                if (r_idle_cnt == c_idle_max) begin
                    r_locked   <= 1'b0;
                    r_grant    <= '0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else if (r_state == ST_IDLE) begin
                r_idle_cnt <= '0;
            end

            if ((r_state == ST_ISSUE) || (r_state == ST_WAIT_BUSY)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            // A finished frame gives up ownership when the byte completes.
            if ((r_state == ST_WAIT_DONE) && !tx_busy && !r_locked) begin
                r_grant <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter with a
//                simple UART stub that holds busy for a programmable time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 3;
    localparam int LOCK_TIMEOUT = 8;
    localparam int BUSY_WAIT    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  grant;
    logic        locked;

    logic        ext_busy;
    logic        stub_en;
    int          stub_len;
    int          stub_cnt = 0;

    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        logic [2:0]  valid;
        logic [23:0] data;
        logic [2:0]  last;
        logic        ext_busy;
        logic [2:0]  exp_ready;
        logic [7:0]  exp_data;
        logic [2:0]  exp_grant;
        logic        exp_locked;
    } vec_t;

    vec_t tbl [12];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .BUSY_WAIT    (BUSY_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // UART stub: busy for stub_len cycles after each start pulse.
    always @(posedge clk) begin
        if (stub_en && tx_start) begin
            stub_cnt <= stub_len;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign tx_busy = (stub_cnt != 0) || ext_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        logic got;

        // {valid, data{r2,r1,r0}, last, ext_busy, exp_ready, exp_data, exp_grant, exp_locked}
        tbl[0]  = '{3'b111, 24'h302010, 3'b111, 1'b0, 3'b001, 8'h10, 3'b001, 1'b0};
        tbl[1]  = '{3'b111, 24'h302010, 3'b111, 1'b0, 3'b010, 8'h20, 3'b010, 1'b0};
        tbl[2]  = '{3'b111, 24'h302010, 3'b111, 1'b0, 3'b100, 8'h30, 3'b100, 1'b0};
        tbl[3]  = '{3'b111, 24'h302010, 3'b111, 1'b0, 3'b001, 8'h10, 3'b001, 1'b0};
        tbl[4]  = '{3'b111, 24'h302010, 3'b111, 1'b0, 3'b010, 8'h20, 3'b010, 1'b0};
        tbl[5]  = '{3'b111, 24'h302010, 3'b111, 1'b0, 3'b100, 8'h30, 3'b100, 1'b0};
        tbl[6]  = '{3'b001, 24'h000011, 3'b001, 1'b0, 3'b001, 8'h11, 3'b001, 1'b0};
        tbl[7]  = '{3'b111, 24'h302010, 3'b111, 1'b1, 3'b000, 8'h00, 3'b000, 1'b0};
        tbl[8]  = '{3'b011, 24'h00A512, 3'b001, 1'b0, 3'b010, 8'hA5, 3'b010, 1'b1};
        tbl[9]  = '{3'b011, 24'h00A612, 3'b001, 1'b0, 3'b010, 8'hA6, 3'b010, 1'b1};
        tbl[10] = '{3'b011, 24'h00A712, 3'b011, 1'b0, 3'b010, 8'hA7, 3'b010, 1'b0};
        tbl[11] = '{3'b011, 24'h00B012, 3'b011, 1'b0, 3'b001, 8'h12, 3'b001, 1'b0};

        // Reset with every requester valid: nothing may be accepted.
        rst       = 1'b1;
        req_valid = 3'b111;
        req_data  = 24'h302010;
        req_last  = 3'b111;
        ext_busy  = 1'b0;
        stub_en   = 1'b1;
        stub_len  = 2;
        repeat (2) @(negedge clk);
        check("rst ready",    32'(req_ready), 32'h0);
        check("rst tx_start", 32'(tx_start),  32'h0);
        check("rst tx_data",  32'(tx_data),   32'h0);
        check("rst grant",    32'(grant),     32'h0);
        check("rst locked",   32'(locked),    32'h0);
        rst       = 1'b0;
        req_valid = 3'b000;

        // Table: round-robin, external busy, frame lock.
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            req_last  = tbl[i].last;
            ext_busy  = tbl[i].ext_busy;
            #1;
            check($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
            @(negedge clk);
            if (tbl[i].exp_ready != 3'b000) begin
                check($sformatf("v%0d tx_start", i), 32'(tx_start), 32'h1);
                check($sformatf("v%0d tx_data", i),  32'(tx_data),  32'(tbl[i].exp_data));
            end else begin
                check($sformatf("v%0d tx_start", i), 32'(tx_start), 32'h0);
            end
            check($sformatf("v%0d grant", i),  32'(grant),  32'(tbl[i].exp_grant));
            check($sformatf("v%0d locked", i), 32'(locked), 32'(tbl[i].exp_locked));
            req_valid = 3'b000;
            ext_busy  = 1'b0;
            if (tbl[i].exp_ready != 3'b000) begin
                repeat (4) @(negedge clk);
            end
        end

        // Lock timeout: req2 opens a frame then goes quiet while req0 waits.
        req_valid = 3'b100;
        req_data  = 24'hC30000;
        req_last  = 3'b000;
        #1;
        check("lto ready req2", 32'(req_ready), 32'h4);
        @(negedge clk);
        check("lto locked set", 32'(locked),  32'h1);
        check("lto tx_data",    32'(tx_data), 32'hC3);
        req_valid = 3'b001;
        req_data  = 24'h00005A;
        req_last  = 3'b001;
        repeat (11) @(negedge clk);
        check("lto still locked", 32'(locked),    32'h1);
        check("lto req0 blocked", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("lto locked clear", 32'(locked),    32'h0);
        check("lto grant clear",  32'(grant),     32'h0);
        check("lto req0 ready",   32'(req_ready), 32'h1);
        @(negedge clk);
        check("lto req0 start",   32'(tx_start), 32'h1);
        check("lto req0 data",    32'(tx_data),  32'h5A);
        req_valid = 3'b000;
        repeat (4) @(negedge clk);

        // Single byte with a 10-cycle busy from the UART.
        stub_len  = 10;
        req_valid = 3'b001;
        req_data  = 24'h00005A;
        req_last  = 3'b001;
        #1;
        check("one ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("one tx_start", 32'(tx_start), 32'h1);
        check("one tx_data",  32'(tx_data),  32'h5A);
        check("one grant",    32'(grant),    32'h1);
        req_valid = 3'b000;
        starts = 0;
        repeat (11) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check("one single pulse", 32'(starts), 32'h0);
        check("one grant held",   32'(grant),  32'h1);
        @(negedge clk);
        check("one grant drop",   32'(grant),  32'h0);

        // Busy timeout: UART never raises busy.
        stub_en   = 1'b0;
        req_valid = 3'b010;
        req_data  = 24'h007700;
        req_last  = 3'b010;
        #1;
        check("bto ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        check("bto tx_start", 32'(tx_start), 32'h1);
        check("bto tx_data",  32'(tx_data),  32'h77);
        req_valid = 3'b000;
        repeat (4) @(negedge clk);
        check("bto grant held", 32'(grant), 32'h2);
        @(negedge clk);
        check("bto grant drop", 32'(grant), 32'h0);

        // Reset during WAIT_DONE with a frame lock held.
        stub_en   = 1'b1;
        stub_len  = 10;
        req_valid = 3'b010;
        req_data  = 24'h009900;
        req_last  = 3'b000;
        #1;
        check("mrst ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        check("mrst tx_start", 32'(tx_start), 32'h1);
        req_valid = 3'b000;
        repeat (3) @(negedge clk);
        check("mrst locked before", 32'(locked), 32'h1);
        check("mrst grant before",  32'(grant),  32'h2);
        rst       = 1'b1;
        req_valid = 3'b111;
        req_data  = 24'h302010;
        req_last  = 3'b111;
        #1;
        check("mrst ready in rst", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("mrst tx_start", 32'(tx_start), 32'h0);
        check("mrst tx_data",  32'(tx_data),  32'h0);
        check("mrst grant",    32'(grant),    32'h0);
        check("mrst locked",   32'(locked),   32'h0);
        #1;
        check("mrst busy blocks", 32'(req_ready), 32'h0);
        got    = 1'b0;
        starts = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (tx_start) starts++;
            if (req_ready != 3'b000) got = 1'b1;
        end
        check("mrst ready seen",   32'(got),       32'h1);
        check("mrst req0 first",   32'(req_ready), 32'h1);
        check("mrst no stray start", 32'(starts),  32'h0);
        @(negedge clk);
        check("mrst req0 start", 32'(tx_start), 32'h1);
        check("mrst req0 data",  32'(tx_data),  32'h10);
        req_valid = 3'b000;
        repeat (14) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
